// File: rtl/pet_need_tracker.sv
// Pet status datapath: per-need raise/neglect tracking, dying/deceased
// escalation, sleep cycles and age, all advanced by a prescaled game tick.
module pet_need_tracker #(
  parameter int NUM_NEEDS    = 4,
  parameter int TICK_CYCLES  = 50_000_000,
  parameter int TICK_W       = 26,
  parameter int LIFE_W       = 9,
  parameter int MAX_LIFE     = 330,
  parameter int PERIOD_W     = 8,
  parameter logic [NUM_NEEDS*PERIOD_W-1:0] NEED_PERIODS = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int GRACE_TICKS  = 4,
  parameter int DYING_TICKS  = 4,
  parameter int SLEEP_PERIOD = 45,
  parameter int SLEEP_TICKS  = 5,
  parameter int AGE_W        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_NEEDS-1:0] care_given,
  output logic                 tick,
  output logic [LIFE_W-1:0]    life_ticks,
  output logic [NUM_NEEDS-1:0] need_active,
  output logic [NUM_NEEDS-1:0] need_shown,
  output logic                 dying,
  output logic                 deceased,
  output logic                 sleeping,
  output logic [AGE_W-1:0]     age
);

  localparam int NEG_W = $clog2(GRACE_TICKS + 1);
  localparam int DYC_W = $clog2(DYING_TICKS + 1);
  localparam int SLP_W = $clog2(SLEEP_PERIOD + SLEEP_TICKS + 1);

  typedef enum logic {AWAKE, ASLEEP} sleep_e;

  function automatic logic [PERIOD_W-1:0] period_m1(input int unsigned idx);
    return NEED_PERIODS[idx*PERIOD_W +: PERIOD_W] - PERIOD_W'(1);
  endfunction

  logic [TICK_W-1:0]   presc_q, presc_d;
  logic [LIFE_W-1:0]   life_q, life_d;
  logic [NUM_NEEDS-1:0] active_q, active_d;
  logic [PERIOD_W-1:0] phase_q [NUM_NEEDS];
  logic [PERIOD_W-1:0] phase_d [NUM_NEEDS];
  logic [NEG_W-1:0]    neglect_q [NUM_NEEDS];
  logic [NEG_W-1:0]    neglect_d [NUM_NEEDS];
  logic                dying_q, dying_d;
  logic [DYC_W-1:0]    dyc_q, dyc_d;
  logic                dead_q, dead_d;
  sleep_e              state_q, state_d;
  logic [SLP_W-1:0]    slp_q, slp_d;
  logic [AGE_W-1:0]    age_q, age_d;
  logic                run, tick_c, awake_tick, any_grace;

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      life_q   <= '0;
      active_q <= '0;
      for (int unsigned i = 0; i < NUM_NEEDS; i++) begin
        phase_q[i]   <= period_m1(i);
        neglect_q[i] <= '0;
      end
      dying_q <= 1'b0;
      dyc_q   <= '0;
      dead_q  <= 1'b0;
      state_q <= AWAKE;
      slp_q   <= SLP_W'(SLEEP_PERIOD - 1);
      age_q   <= '0;
    end else begin
      presc_q  <= presc_d;
      life_q   <= life_d;
      active_q <= active_d;
      for (int unsigned i = 0; i < NUM_NEEDS; i++) begin
        phase_q[i]   <= phase_d[i];
        neglect_q[i] <= neglect_d[i];
      end
      dying_q <= dying_d;
      dyc_q   <= dyc_d;
      dead_q  <= dead_d;
      state_q <= state_d;
      slp_q   <= slp_d;
      age_q   <= age_d;
    end
  end

  // Next-state: prescaler, needs, dying/deceased escalation, sleep FSM
  always_comb begin
    run        = enable && !dead_q;
    tick_c     = run && (presc_q == TICK_W'(TICK_CYCLES - 1));
    awake_tick = tick_c && (state_q == AWAKE);
    presc_d    = presc_q;
    life_d     = life_q;
    active_d   = active_q;
    dead_d     = dead_q;
    dyc_d      = dyc_q;
    state_d    = state_q;
    slp_d      = slp_q;
    age_d      = age_q;
    any_grace  = 1'b0;

    if (run) presc_d = tick_c ? '0 : presc_q + TICK_W'(1);

    // Care is applied after the tick update so that it wins over a raise
    // or a neglect increment landing on the same edge.
    for (int unsigned i = 0; i < NUM_NEEDS; i++) begin
      phase_d[i]   = phase_q[i];
      neglect_d[i] = neglect_q[i];
      if (awake_tick) begin
        if (active_q[i] && (neglect_q[i] != NEG_W'(GRACE_TICKS)))
          neglect_d[i] = neglect_q[i] + NEG_W'(1);
        if (phase_q[i] == '0) begin
          phase_d[i]  = period_m1(i);
          active_d[i] = 1'b1;
        end else begin
          phase_d[i] = phase_q[i] - PERIOD_W'(1);
        end
      end
      if (care_given[i] && !dead_q) begin
        active_d[i]  = 1'b0;
        neglect_d[i] = '0;
      end
      if (neglect_d[i] == NEG_W'(GRACE_TICKS)) any_grace = 1'b1;
    end

    if (tick_c) begin
      life_d = life_q + LIFE_W'(1);
      if (life_d == LIFE_W'(MAX_LIFE)) dead_d = 1'b1;
      if (dying_q && (dyc_q != DYC_W'(DYING_TICKS))) dyc_d = dyc_q + DYC_W'(1);
      if (dyc_d == DYC_W'(DYING_TICKS)) dead_d = 1'b1;

      case (state_q)
        AWAKE: begin
          if (slp_q != '0) begin
            slp_d = slp_q - SLP_W'(1);
          end else if (!dying_q) begin
            state_d = ASLEEP;
            slp_d   = SLP_W'(SLEEP_TICKS - 1);
          end
        end
        ASLEEP: begin
          if (slp_q != '0) begin
            slp_d = slp_q - SLP_W'(1);
          end else begin
            state_d = AWAKE;
            slp_d   = SLP_W'(SLEEP_PERIOD - 1);
            if (age_q != '1) age_d = age_q + AGE_W'(1);
          end
        end
        default: state_d = AWAKE;
      endcase
    end

    dying_d = any_grace && !dead_d;
    if (!dying_d) dyc_d = '0;
  end

  assign tick        = tick_c;
  assign life_ticks  = life_q;
  assign need_active = active_q;
  assign need_shown  = (dying_q || dead_q) ? '0 : (active_q & (~active_q + NUM_NEEDS'(1)));
  assign dying       = dying_q && !dead_q;
  assign deceased    = dead_q;
  assign sleeping    = (state_q == ASLEEP) && !dead_q;
  assign age         = age_q;

endmodule

// File: tb/tb_pet_need_tracker.sv
// Directed bench for pet_need_tracker with a short tick and two needs.
module tb_pet_need_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] care_given = 2'b00;
  logic       tick;
  logic [8:0] life_ticks;
  logic [1:0] need_active;
  logic [1:0] need_shown;
  logic       dying;
  logic       deceased;
  logic       sleeping;
  logic [3:0] age;

  int vectors = 0;
  int errors  = 0;

  pet_need_tracker #(
    .NUM_NEEDS(2), .TICK_CYCLES(4), .TICK_W(3), .LIFE_W(9), .MAX_LIFE(40),
    .PERIOD_W(8), .NEED_PERIODS(16'h0302), .GRACE_TICKS(2), .DYING_TICKS(2),
    .SLEEP_PERIOD(10), .SLEEP_TICKS(2), .AGE_W(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .care_given(care_given),
    .tick(tick), .life_ticks(life_ticks), .need_active(need_active),
    .need_shown(need_shown), .dying(dying), .deceased(deceased),
    .sleeping(sleeping), .age(age)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    care_given = 2'b00;
    step();
    reset = 1'b0;
  endtask

  // Wait for the tick cycle (bounded), optionally pulse care on it, cross its edge.
  task automatic one_tick(input logic [1:0] c, output int waited);
    logic [1:0] saved;
    waited = 0;
    while (!tick && waited < 20) begin
      step();
      waited++;
    end
    if (!tick) begin
      check("tick_timeout", 0, 1);
    end else begin
      saved = care_given;
      if (c != 2'b00) care_given = c;
      step();
      care_given = saved;
    end
  endtask

  task automatic ticks(input int n);
    int w;
    for (int k = 0; k < n; k++) one_tick(2'b00, w);
  endtask

  task automatic count_ticks(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      if (tick) seen++;
      step();
    end
  endtask

  initial begin
    int w;
    int seen;

    // Reset state and raise timing
    enable = 1'b1;
    do_reset();
    check("rst_tick", tick, 0);
    check("rst_life", life_ticks, 0);
    check("rst_active", need_active, 0);
    check("rst_shown", need_shown, 0);
    check("rst_dying", dying, 0);
    check("rst_deceased", deceased, 0);
    check("rst_sleeping", sleeping, 0);
    check("rst_age", age, 0);
    one_tick(2'b00, w);
    check("first_tick_wait", w, 3);
    check("t1_active", need_active, 2'b00);
    check("t1_life", life_ticks, 1);
    one_tick(2'b00, w);
    check("tick_period_wait", w, 3);
    check("t2_active", need_active, 2'b01);
    check("t2_shown", need_shown, 2'b01);
    ticks(1);
    check("t3_active", need_active, 2'b11);
    check("t3_shown", need_shown, 2'b01);
    check("t3_dying", dying, 0);

    // Neglect to dying, then deceased
    ticks(1);
    check("t4_dying", dying, 1);
    check("t4_shown", need_shown, 2'b00);
    ticks(1);
    check("t5_deceased", deceased, 0);
    check("t5_dying", dying, 1);
    ticks(1);
    check("t6_deceased", deceased, 1);
    check("t6_dying", dying, 0);
    check("t6_life", life_ticks, 6);
    count_ticks(12, seen);
    check("dead_no_tick", seen, 0);
    check("dead_life_frozen", life_ticks, 6);
    care_given = 2'b11;
    step();
    care_given = 2'b00;
    step();
    check("dead_care_ignored", need_active, 2'b11);

    // Care on the raise edge, then rescue from dying
    do_reset();
    ticks(1);
    one_tick(2'b01, w);
    check("care_beats_raise", need_active, 2'b00);
    ticks(1);
    check("t3b_active", need_active, 2'b10);
    check("t3b_shown", need_shown, 2'b10);
    ticks(1);
    check("t4b_active", need_active, 2'b11);
    check("t4b_shown", need_shown, 2'b01);
    check("t4b_no_neglect0", dying, 0);
    ticks(1);
    check("t5b_dying", dying, 1);
    ticks(1);
    check("t6b_deceased", deceased, 0);
    care_given = 2'b11;
    step();
    care_given = 2'b00;
    check("rescue_dying", dying, 0);
    check("rescue_active", need_active, 2'b00);
    ticks(2);
    check("t8b_active", need_active, 2'b01);
    ticks(1);
    check("t9b_active", need_active, 2'b11);
    ticks(1);
    check("t10b_dying", dying, 1);
    check("t10b_sleeping", sleeping, 1);
    ticks(1);
    check("t11b_deceased", deceased, 0);
    ticks(1);
    check("t12b_deceased", deceased, 1);
    check("t12b_sleeping", sleeping, 0);

    // Enable freeze, sleep cycle, age, old-age death and reset
    enable = 1'b0;
    do_reset();
    count_ticks(8, seen);
    check("disabled_no_tick", seen, 0);
    check("disabled_life", life_ticks, 0);
    enable = 1'b1;
    care_given = 2'b11;
    ticks(9);
    check("t9_sleeping", sleeping, 0);
    ticks(1);
    check("t10_sleeping", sleeping, 1);
    care_given = 2'b00;
    ticks(1);
    check("t11_sleeping", sleeping, 1);
    check("t11_active", need_active, 2'b00);
    ticks(1);
    check("t12_sleeping", sleeping, 0);
    check("t12_age", age, 1);
    check("t12_no_raise", need_active, 2'b00);
    ticks(1);
    check("t13_active", need_active, 2'b00);
    ticks(1);
    check("t14_active", need_active, 2'b11);
    care_given = 2'b11;
    ticks(25);
    check("t39_life", life_ticks, 39);
    check("t39_deceased", deceased, 0);
    check("t39_age", age, 3);
    ticks(1);
    check("t40_life", life_ticks, 40);
    check("t40_deceased", deceased, 1);
    check("t40_sleeping", sleeping, 0);
    count_ticks(10, seen);
    check("old_age_no_tick", seen, 0);
    care_given = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rerst_deceased", deceased, 0);
    check("rerst_life", life_ticks, 0);
    check("rerst_age", age, 0);
    check("rerst_active", need_active, 0);
    check("rerst_tick", tick, 0);
    check("rerst_dying", dying, 0);
    check("rerst_sleeping", sleeping, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
